alu_unit: RTL and testbench

- Registered N-bit arithmetic/logic unit driven by board push-buttons (active-low opcode) plus two direct add/subtract strobes.
- Computes all operations in parallel each cycle; registers the selected result and each dedicated per-operation output.
- Used as the compute block of the lab datapath, feeding displays/LEDs.

---
 rtl/alu_unit_if.sv | 31 +++
 rtl/alu_unit.sv | 91 +++++++++
 tb/tb_alu_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - operand/opcode inputs and registered result outputs of alu_unit
interface alu_unit_if #(
  parameter int N = 4
);
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2:0]     op;
  logic           op_sum;
  logic           op_subt;
  logic [N-1:0]   result;
  logic [N-1:0]   sumResult;
  logic [N-1:0]   subResult;
  logic [N-1:0]   diviResult;
  logic [N-1:0]   moduResult;
  logic [N-1:0]   andResult;
  logic [2*N-1:0] multiResult;
  logic           carryingSum;
  logic           carryingSub;

  modport master (
    output a, b, op, op_sum, op_subt,
    input  result, sumResult, subResult, diviResult, moduResult, andResult,
           multiResult, carryingSum, carryingSub
  );

  modport slave (
    input  a, b, op, op_sum, op_subt,
    output result, sumResult, subResult, diviResult, moduResult, andResult,
           multiResult, carryingSum, carryingSub
  );
endinterface

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered N-bit ALU with active-low opcode and add/sub strobes
// Define ALU_SHIFT_EN to turn opcodes 6/7 into logical shift left/right.
module alu_unit #(
  parameter int N = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_unit_if.slave bus
);

  logic [N:0]     sum_ext;
  logic [N:0]     sub_ext;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;
  logic [N:0]     trial;
  logic [2:0]     idx;
  logic [N-1:0]   sel;

  assign sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
  // Top bit of the widened difference is the borrow (set when a < b).
  assign sub_ext = {1'b0, bus.a} - {1'b0, bus.b};
  assign prod    = {{N{1'b0}}, bus.a} * {{N{1'b0}}, bus.b};
  assign idx     = ~bus.op;

  // Restoring division; with b == 0 every trial succeeds, giving quotient all
  // ones and remainder a without any special casing.
  always_comb begin
    quo   = '0;
    rem   = '0;
    trial = '0;
    for (int i = N - 1; i >= 0; i--) begin
      trial = {rem, bus.a[i]};
      if (trial >= {1'b0, bus.b}) begin
        trial  = trial - {1'b0, bus.b};
        quo[i] = 1'b1;
      end
      rem = trial[N-1:0];
    end
  end

  always_comb begin
    sel = '0;
    if (bus.op_sum) begin
      sel = sum_ext[N-1:0];
    end else if (bus.op_subt) begin
      sel = sub_ext[N-1:0];
    end else begin
      case (idx)
        3'd0:    sel = sum_ext[N-1:0];
        3'd1:    sel = sub_ext[N-1:0];
        3'd2:    sel = prod[N-1:0];
        3'd3:    sel = quo;
        3'd4:    sel = rem;
        3'd5:    sel = bus.a & bus.b;
`ifdef ALU_SHIFT_EN
        3'd6:    sel = bus.a << bus.b;
        default: sel = bus.a >> bus.b;
`else
        3'd6:    sel = bus.a | bus.b;
        default: sel = bus.a ^ bus.b;
`endif
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result      <= '0;
      bus.sumResult   <= '0;
      bus.subResult   <= '0;
      bus.diviResult  <= '0;
      bus.moduResult  <= '0;
      bus.andResult   <= '0;
      bus.multiResult <= '0;
      bus.carryingSum <= 1'b0;
      bus.carryingSub <= 1'b0;
    end else begin
      bus.result      <= sel;
      bus.sumResult   <= sum_ext[N-1:0];
      bus.subResult   <= sub_ext[N-1:0];
      bus.diviResult  <= quo;
      bus.moduResult  <= rem;
      bus.andResult   <= bus.a & bus.b;
      bus.multiResult <= prod;
      bus.carryingSum <= sum_ext[N];
      bus.carryingSub <= sub_ext[N];
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed self-checking bench for alu_unit
module tb_alu_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  alu_unit_if #(.N(4)) bus ();

  alu_unit #(.N(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic s, input logic t);
    bus.a       = a;
    bus.b       = b;
    bus.op      = op;
    bus.op_sum  = s;
    bus.op_subt = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 3'b111, 1'b0, 1'b0);
    check("rst_result", {12'h0, bus.result}, 16'h0);
    check("rst_sum",    {12'h0, bus.sumResult}, 16'h0);
    check("rst_mult",   {8'h0, bus.multiResult}, 16'h0);
    check("rst_flags",  {14'h0, bus.carryingSum, bus.carryingSub}, 16'h0);
    check("rst_div",    {8'h0, bus.diviResult, bus.moduResult}, 16'h0);

    rst = 1'b0;
    drive(4'b1000, 4'b0000, 3'b111, 1'b0, 1'b0);
    check("add_result", {12'h0, bus.result}, 16'h8);
    check("add_sum",    {12'h0, bus.sumResult}, 16'h8);
    check("add_carry",  {15'h0, bus.carryingSum}, 16'h0);

    drive(4'b1001, 4'b1001, 3'b110, 1'b0, 1'b0);
    check("sub_result", {12'h0, bus.result}, 16'h0);
    check("sub_sub",    {12'h0, bus.subResult}, 16'h0);
    check("sub_borrow", {15'h0, bus.carryingSub}, 16'h0);
    check("sub_and",    {12'h0, bus.andResult}, 16'h9);

    drive(4'b1010, 4'b0010, 3'b101, 1'b0, 1'b0);
    check("mul_full",   {8'h0, bus.multiResult}, 16'h14);
    check("mul_result", {12'h0, bus.result}, 16'h4);
    check("mul_sum",    {12'h0, bus.sumResult}, 16'hC);
    check("mul_subr",   {12'h0, bus.subResult}, 16'h8);
    drive(4'b1010, 4'b0010, 3'b100, 1'b0, 1'b0);
    check("div_result", {12'h0, bus.result}, 16'h5);
    drive(4'b1010, 4'b0010, 3'b011, 1'b0, 1'b0);
    check("mod_result", {12'h0, bus.result}, 16'h0);

    drive(4'b1011, 4'b0000, 3'b100, 1'b0, 1'b0);
    check("div0_quo",    {12'h0, bus.diviResult}, 16'hF);
    check("div0_result", {12'h0, bus.result}, 16'hF);
    check("div0_rem",    {12'h0, bus.moduResult}, 16'hB);
    drive(4'b1011, 4'b0000, 3'b011, 1'b0, 1'b0);
    check("mod0_result", {12'h0, bus.result}, 16'hB);

    drive(4'b0111, 4'b0010, 3'b111, 1'b0, 1'b0);
    check("div_7_2",    {8'h0, bus.diviResult, bus.moduResult}, 16'h31);

    drive(4'b1111, 4'b1000, 3'b010, 1'b1, 1'b0);
    check("opsum_result", {12'h0, bus.result}, 16'h7);
    check("opsum_carry",  {15'h0, bus.carryingSum}, 16'h1);
    drive(4'b1111, 4'b1000, 3'b010, 1'b1, 1'b1);
    check("both_result",  {12'h0, bus.result}, 16'h7);
    check("both_carry",   {15'h0, bus.carryingSum}, 16'h1);
    drive(4'b1111, 4'b1111, 3'b010, 1'b0, 1'b1);
    check("opsubt_result", {12'h0, bus.result}, 16'h0);
    check("opsubt_borrow", {15'h0, bus.carryingSub}, 16'h0);
    drive(4'b0011, 4'b0101, 3'b010, 1'b0, 1'b1);
    check("wrap_result",  {12'h0, bus.result}, 16'hE);
    check("wrap_borrow",  {15'h0, bus.carryingSub}, 16'h1);

    drive(4'b1100, 4'b1010, 3'b010, 1'b0, 1'b0);
    check("and_result", {12'h0, bus.result}, 16'h8);
    drive(4'b1100, 4'b1010, 3'b001, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
    check("idx6_result", {12'h0, bus.result}, 16'h0);
`else
    check("idx6_result", {12'h0, bus.result}, 16'hE);
`endif
    drive(4'b1100, 4'b1010, 3'b000, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
    check("idx7_result", {12'h0, bus.result}, 16'h0);
`else
    check("idx7_result", {12'h0, bus.result}, 16'h6);
`endif

    rst = 1'b1;
    drive(4'b0101, 4'b0011, 3'b101, 1'b0, 1'b0);
    check("midrst_result", {12'h0, bus.result}, 16'h0);
    check("midrst_mult",   {8'h0, bus.multiResult}, 16'h0);
    rst = 1'b0;
    drive(4'b0101, 4'b0011, 3'b101, 1'b0, 1'b0);
    check("after_rst_mul", {8'h0, bus.multiResult}, 16'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
